// File: rtl/my_spi_pkg.sv
// my_spi_pkg: types and constants shared by the SPI register-access master
// and its responder.
//   state_t       master sequencing states
//   A_*           responder register map addresses (7-bit)
package my_spi_pkg;

  typedef enum logic [2:0] {
    S_Idle,
    S_Setup,
    S_Low,
    S_High,
    S_Hold,
    S_Gap
  } state_t;

  localparam logic [6:0] A_Config  = 7'h00;
  localparam logic [6:0] A_Status  = 7'h01;
  localparam logic [6:0] A_dirR    = 7'h10;
  localparam logic [6:0] A_speedR1 = 7'h11;
  localparam logic [6:0] A_speedR2 = 7'h12;
  localparam logic [6:0] A_dirL    = 7'h20;
  localparam logic [6:0] A_speedL1 = 7'h21;
  localparam logic [6:0] A_speedL2 = 7'h22;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk  in   destination clock
//   rst  in   synchronous active-high reset (clears both flops)
//   d    in   asynchronous input
//   q    out  synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/my_spi_master.sv
// my_spi_master: single 16-bit SPI transaction initiator ({write, addr[6:0]}
// command byte then one data byte, MSB first, CS active-low, SCLK idle low).
//   theClock    in   system clock
//   theReset    in   synchronous active-high reset
//   start       in   request pulse, accepted only while busy=0
//   write       in   1 = write, 0 = read
//   addr[6:0]   in   register address
//   wdata[7:0]  in   write data (ignored by responder on reads)
//   busy        out  transaction in progress, including trailing CS-high gap
//   done        out  one-cycle pulse when CS rises at the end of a transaction
//   rdata[7:0]  out  byte shifted in during the data phase, held until next done
//   MySPI_clk   out  SCLK
//   MySPI_cs    out  chip select, active-low
//   MySPI_mosi  out  serial data to responder
//   MySPI_miso  in   serial data from responder (asynchronous)
//
// state   | meaning
// S_Idle  | CS high, waiting for start
// S_Setup | CS low, SCLK low, CS_SETUP cycles before the first bit
// S_Low   | SCLK low half period; MISO sampled on its last cycle
// S_High  | SCLK high half period; exit is the falling edge, tx shifts
// S_Hold  | CS still low after the last falling edge, CS_HOLD cycles
// S_Gap   | CS high, minimum gap before the next transaction, CS_HOLD cycles
module my_spi_master
  import my_spi_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 16,
  parameter int unsigned CS_SETUP    = 8,
  parameter int unsigned CS_HOLD     = 8
) (
  input  logic       theClock,
  input  logic       theReset,
  input  logic       start,
  input  logic       write,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       MySPI_clk,
  output logic       MySPI_cs,
  output logic       MySPI_mosi,
  input  logic       MySPI_miso
);

  localparam int unsigned MAX_SH  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_MAX = (HALF_PERIOD > MAX_SH) ? HALF_PERIOD : MAX_SH;
  localparam int          CW      = $clog2(CNT_MAX);

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_d;
  logic [3:0]      bit_cnt, bit_d;
  logic [15:0]     tx, tx_d;
  logic [7:0]      rx, rx_d;
  logic [7:0]      rdata_d;
  logic            miso_s;
  logic            last;
  logic            cs_low_d, sclk_d, mosi_d, busy_d, done_d;

  // Cycle count for the state being entered; the counter runs down to zero.
  function automatic logic [CW-1:0] reload(state_t s);
    case (s)
      S_Setup:        reload = CW'(CS_SETUP - 1);
      S_Low, S_High:  reload = CW'(HALF_PERIOD - 1);
      S_Hold, S_Gap:  reload = CW'(CS_HOLD - 1);
      default:        reload = '0;
    endcase
  endfunction

  sync_2ff u_miso_sync (
    .clk (theClock),
    .rst (theReset),
    .d   (MySPI_miso),
    .q   (miso_s)
  );

  assign last = (cnt == '0);

  // State, datapath and output registers. Every pin is a flop fed from the
  // next-state decode, so the pins change only on clock edges.
  always_ff @(posedge theClock) begin
    if (theReset) begin
      state      <= S_Idle;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      rdata      <= '0;
      MySPI_cs   <= 1'b1;
      MySPI_clk  <= 1'b0;
      MySPI_mosi <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_d;
      bit_cnt    <= bit_d;
      tx         <= tx_d;
      rx         <= rx_d;
      rdata      <= rdata_d;
      MySPI_cs   <= ~cs_low_d;
      MySPI_clk  <= sclk_d;
      MySPI_mosi <= mosi_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_Idle:  if (start) next_state = S_Setup;
      S_Setup: if (last)  next_state = S_Low;
      S_Low:   if (last)  next_state = S_High;
      S_High:  if (last)  next_state = (bit_cnt == 4'd15) ? S_Hold : S_Low;
      S_Hold:  if (last)  next_state = S_Gap;
      S_Gap:   if (last)  next_state = S_Idle;
      default:            next_state = S_Idle;
    endcase
  end

  always_comb begin
    cs_low_d = (next_state == S_Setup) || (next_state == S_Low) ||
               (next_state == S_High)  || (next_state == S_Hold);
    sclk_d   = (next_state == S_High);
    busy_d   = (next_state != S_Idle);
    done_d   = (state == S_Hold) && last;

    tx_d = tx;
    if (state == S_Idle && start)
      tx_d = {write, addr, wdata};
    else if (state == S_High && last)
      tx_d = {tx[14:0], 1'b0};

    mosi_d = cs_low_d ? tx_d[15] : 1'b0;

    bit_d = bit_cnt;
    if (state == S_Idle && start)
      bit_d = '0;
    else if (state == S_High && last && bit_cnt != 4'd15)
      bit_d = bit_cnt + 4'd1;

    // Only the last eight samples survive in rx, i.e. the data-phase bits.
    rx_d = rx;
    if (state == S_Low && last)
      rx_d = {rx[6:0], miso_s};

    rdata_d = done_d ? rx : rdata;

    if (next_state != state)
      cnt_d = reload(next_state);
    else if (!last)
      cnt_d = cnt - CW'(1);
    else
      cnt_d = cnt;
  end

endmodule

// File: tb/tb_my_spi_master.sv
module tb_my_spi_master;
  import my_spi_pkg::*;

  localparam int HP     = 8;
  localparam int CSS    = 6;
  localparam int CSH    = 4;
  localparam int DONE_K = 1 + CSS + 32*HP + CSH;    // 267: CS rises, done pulses
  localparam int TOTAL  = CSS + 32*HP + 2*CSH;      // 270 busy cycles

  localparam logic [7:0]  LIT_RDATA [0:5] = '{8'h3C, 8'hAA, 8'h12, 8'h34, 8'h05, 8'h05};
  localparam logic [15:0] LIT_FRAME [0:5] = '{16'h8005, 16'h0100, 16'h1100,
                                               16'h1200, 16'h0000, 16'h0000};

  logic       theClock = 1'b0;
  logic       theReset;
  logic       start, write;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done;
  logic [7:0] rdata;
  logic       MySPI_clk, MySPI_cs, MySPI_mosi;
  logic       MySPI_miso = 1'b0;

  always #5 theClock = ~theClock;

  my_spi_master #(.HALF_PERIOD(HP), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut (
    .theClock   (theClock),
    .theReset   (theReset),
    .start      (start),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .MySPI_clk  (MySPI_clk),
    .MySPI_cs   (MySPI_cs),
    .MySPI_mosi (MySPI_mosi),
    .MySPI_miso (MySPI_miso)
  );

  // ---------------- behavioural responder ----------------
  logic [7:0]  regs [0:127];
  logic [15:0] r_shift, last_frame;
  logic [7:0]  miso_sh;
  int          r_cnt;
  logic        prev_cs, prev_clk;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[A_Config]  = 8'h3C;
    regs[A_Status]  = 8'hAA;
    regs[A_speedR1] = 8'h12;
    regs[A_speedR2] = 8'h34;
    r_shift = '0; last_frame = 16'hFFFF; miso_sh = '0; r_cnt = 0;
    prev_cs = 1'b1; prev_clk = 1'b0;
    forever begin
      @(MySPI_cs or MySPI_clk);
      if (MySPI_cs !== prev_cs) begin
        if (MySPI_cs === 1'b0) begin
          r_cnt = 0; r_shift = '0; miso_sh = '0; MySPI_miso = 1'b0;
        end else if (r_cnt == 16) begin
          last_frame = r_shift;
          if (r_shift[15]) regs[r_shift[14:8]] = r_shift[7:0];
        end
      end else if (MySPI_cs === 1'b0 && MySPI_clk !== prev_clk) begin
        if (MySPI_clk === 1'b1) begin
          r_shift = {r_shift[14:0], MySPI_mosi};
          r_cnt++;
        end else begin
          if (r_cnt == 8) miso_sh = regs[r_shift[6:0]];
          else if (r_cnt > 8) miso_sh = {miso_sh[6:0], 1'b0};
          MySPI_miso = (r_cnt >= 8) ? miso_sh[7] : 1'b0;
        end
      end
      prev_cs = MySPI_cs;
      prev_clk = MySPI_clk;
    end
  end

  // ---------------- transaction-level model ----------------
  // k = cycles since the accepted start edge (0 = idle).
  int          k = 0;
  logic [15:0] frame = '0;
  logic [7:0]  snap = '0;
  logic [7:0]  exp_rdata = '0;

  always @(posedge theClock) begin
    if (theReset) begin
      k = 0;
      exp_rdata = 8'h00;
    end else if (k == 0) begin
      if (start) begin
        k = 1;
        frame = {write, addr, wdata};
        snap = regs[addr];
      end
    end else begin
      k = (k == TOTAL) ? 0 : k + 1;
      if (k == DONE_K) exp_rdata = snap;
    end
  end

  // {cs, clk, mosi, busy, done} expected at offset kk of a frame
  function automatic logic [4:0] exp_pins(int kk, logic [15:0] fr);
    logic cs, ck, mo, bz, dn;
    int p, b;
    cs = 1'b1; ck = 1'b0; mo = 1'b0; bz = 1'b0; dn = 1'b0;
    if (kk >= 1) begin
      bz = 1'b1;
      cs = (kk >= DONE_K);
      dn = (kk == DONE_K);
      if (kk < 1 + CSS) begin
        mo = fr[15];
      end else if (kk < 1 + CSS + 32*HP) begin
        p  = kk - 1 - CSS;
        b  = p / (2*HP);
        ck = ((p % (2*HP)) >= HP);
        mo = fr[15-b];
      end
    end
    return {cs, ck, mo, bz, dn};
  endfunction

  // ---------------- compare process ----------------
  int   tests = 0, fails = 0;
  int   tmo = 0;
  bit   checking = 0, finish_req = 0;
  int   ncyc = 0, busy_len = 0, cs_len = 0, fall_cyc = 0, n_done = 0;
  bit   done_seen = 0, rise_pending = 0;
  logic p_busy = 0, p_cs = 1, p_clk = 0, p_mosi = 0;
  logic [4:0] got, expv;

  always @(negedge theClock) begin
    ncyc++;
    if (checking) begin
      got  = {MySPI_cs, MySPI_clk, MySPI_mosi, busy, done};
      expv = exp_pins(k, frame);
      tests++;
      if (got !== expv) begin
        fails++;
        $display("FAIL pins cyc=%0d k=%0d {cs,clk,mosi,busy,done} got=%b want=%b", ncyc, k, got, expv);
      end
      tests++;
      if (rdata !== exp_rdata) begin
        fails++;
        $display("FAIL rdata cyc=%0d got=%h want=%h", ncyc, rdata, exp_rdata);
      end
      if (MySPI_mosi !== p_mosi) begin
        tests++;
        if (MySPI_clk !== 1'b0) begin
          fails++;
          $display("FAIL mosi_edge cyc=%0d mosi changed with clk=%b want 0", ncyc, MySPI_clk);
        end
      end
      if (MySPI_cs === 1'b0 && p_cs === 1'b1) begin
        fall_cyc = ncyc; rise_pending = 1;
      end
      if (MySPI_clk === 1'b1 && p_clk === 1'b0 && rise_pending) begin
        rise_pending = 0;
        tests++;
        if (ncyc - fall_cyc != 14) begin
          fails++;
          $display("FAIL first_rise got=%0d want=14", ncyc - fall_cyc);
        end
      end
      if (MySPI_cs === 1'b0) cs_len++;
      if (MySPI_cs === 1'b1 && p_cs === 1'b0) begin
        if (done === 1'b1) begin
          tests++;
          if (cs_len != 266) begin
            fails++;
            $display("FAIL cs_low_len got=%0d want=266", cs_len);
          end
        end
        cs_len = 0;
      end
      if (busy === 1'b1) busy_len++;
      if (done === 1'b1) begin
        done_seen = 1;
        tests++;
        if (n_done > 5) begin
          fails++;
          $display("FAIL extra_done count=%0d want<=6", n_done + 1);
        end else begin
          if (rdata !== LIT_RDATA[n_done] || last_frame !== LIT_FRAME[n_done]) begin
            fails++;
            $display("FAIL txn%0d rdata=%h frame=%h want rdata=%h frame=%h",
                     n_done, rdata, last_frame, LIT_RDATA[n_done], LIT_FRAME[n_done]);
          end
        end
        n_done++;
      end
      if (busy === 1'b0 && p_busy === 1'b1) begin
        if (done_seen) begin
          tests++;
          if (busy_len != 270) begin
            fails++;
            $display("FAIL busy_len got=%0d want=270", busy_len);
          end
        end
        busy_len = 0;
        done_seen = 0;
      end
    end
    p_busy = busy; p_cs = MySPI_cs; p_clk = MySPI_clk; p_mosi = MySPI_mosi;

    if (finish_req) begin
      tests++;
      if (n_done != 6) begin
        fails++;
        $display("FAIL done_total got=%0d want=6", n_done);
      end
      tests++;
      if (regs[A_Config] !== 8'h05) begin
        fails++;
        $display("FAIL config_after_abort got=%h want=05", regs[A_Config]);
      end
      tests++;
      if (tmo != 0) begin
        fails++;
        $display("FAIL timeouts got=%0d want=0", tmo);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic w, input logic [6:0] a, input logic [7:0] d);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (busy === 1'b0) break;
      @(negedge theClock);
    end
    if (i == 2000) begin
      tmo++;
      $display("FAIL issue_wait busy stuck high");
    end
    start = 1'b1; write = w; addr = a; wdata = d;
    @(negedge theClock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge theClock);
      if (done === 1'b1) return;
    end
    tmo++;
    $display("FAIL wait_done no done pulse within 1000 cycles");
  endtask

  initial begin
    theReset = 1'b1; start = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge theClock);
    theReset = 1'b0;
    checking = 1;
    repeat (2) @(negedge theClock);

    issue(1'b1, A_Config, 8'h05);   wait_done();
    issue(1'b0, A_Status, 8'h00);   wait_done();
    issue(1'b0, A_speedR1, 8'h00);  wait_done();
    issue(1'b0, A_speedR2, 8'h00);  wait_done();

    // stray start while busy must be ignored
    issue(1'b0, A_Config, 8'h00);
    repeat (40) @(negedge theClock);
    start = 1'b1; write = 1'b1; addr = A_Status; wdata = 8'hEE;
    @(negedge theClock);
    start = 1'b0;
    wait_done();

    // reset during bit 6 of a write (k = 105)
    issue(1'b1, A_Config, 8'hFF);
    repeat (104) @(negedge theClock);
    theReset = 1'b1;
    @(negedge theClock);
    theReset = 1'b0;
    repeat (30) @(negedge theClock);

    issue(1'b0, A_Config, 8'h00);   wait_done();
    repeat (CSH + 5) @(negedge theClock);
    finish_req = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/my_spi_master.md
# my_spi_master

Single-transaction SPI initiator that drives the board's 16-bit register-access protocol from the host side: one command byte ({write, addr[6:0]}) then one data byte, MSB first, CS active-low, SCLK idle low. It lets FPGA-internal logic (or a test harness) read and write the register map of the MySPI-style responder, e.g. Config, Status, motor speed/direction registers. It sits between a simple start/done request port and the four SPI pins.

## Interface
- HALF_PERIOD, 16, theClock cycles per SCLK half period; legal minimum 8.
- CS_SETUP, 8, cycles CS is low before the first SCLK rising edge; minimum 4.
- CS_HOLD, 8, cycles CS stays low after the last SCLK falling edge, and minimum CS-high gap before the next transaction; minimum 4.
- Clocking: one clock; reset is synchronous and active-high.
- theClock  in  1  system clock.
- theReset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only when busy=0.
- write  in  1  1 = write transaction, 0 = read.
- addr  in  7  register address.
- wdata  in  8  write data; don't-care for reads.
- busy  out  1  transaction in progress (including trailing gap).
- done  out  1  one-cycle pulse at transaction completion.
- rdata  out  8  byte shifted in during the data phase; held until next done.
- MySPI_clk  out  1  SCLK.
- MySPI_cs  out  1  chip select, active-low.
- MySPI_mosi  out  1  serial data to responder.
- MySPI_miso  in  1  serial data from responder (asynchronous).

## Operation
- Reset values: MySPI_cs=1, MySPI_clk=0, MySPI_mosi=0, busy=0, done=0, rdata=8'h00; FSM to S_Idle.
- On start with busy=0: latch tx shift register = {write, addr, wdata} (16 bits); clear bit counter; go to S_Setup. start while busy=1 is ignored (no queueing).
- MOSI = tx[15] whenever CS is low; tx shifts left by one on each SCLK falling edge (HIGH→LOW transition), so data is stable around every rising edge.
- MISO passes through a 2-FF synchronizer; the synchronized value is sampled into rx shift register on the last cycle of each LOW half period (immediately before SCLK rises). rx bits sampled during bits 8..15 form rdata.
- rdata updates on done for both reads and writes (for a write it carries the register's previous value).
- FSM: S_Idle → (start) S_Setup [CS low, SCLK low, CS_SETUP cycles] → S_Low [HALF_PERIOD cycles] → S_High [SCLK high, HALF_PERIOD cycles] → S_Low while bit counter < 15 (counter increments on HIGH exit), else → S_Hold [SCLK low, CS low, CS_HOLD cycles] → S_Gap [CS high, CS_HOLD cycles] → S_Idle.
- Counters: cycle counter sized for max(HALF_PERIOD, CS_SETUP, CS_HOLD), reloaded on every state entry; bit counter 4 bits, 0..15, no wrap beyond 15.
- theReset mid-transaction: next edge returns to reset values; CS rises immediately, no done pulse, rdata unchanged from reset value (8'h00).

## Timing
- start sampled at cycle 0; MySPI_cs falls and busy rises at cycle 1.
- First SCLK rising edge at cycle 1 + CS_SETUP + HALF_PERIOD.
- MySPI_cs rises at cycle 1 + CS_SETUP + 32·HALF_PERIOD + CS_HOLD; done pulses and rdata updates on that same cycle.
- busy falls CS_HOLD cycles after CS rises; total busy = CS_SETUP + 32·HALF_PERIOD + 2·CS_HOLD cycles. Defaults: 536 cycles.
- start in the cycle busy falls is accepted (back-to-back allowed).
- All SPI outputs are registered (glitch-free).

## Structure
- Package my_spi_pkg: master state enum (S_Idle, S_Setup, S_Low, S_High, S_Hold, S_Gap) and register address constants (A_Config=7'h00, A_Status=7'h01, A_dirR=7'h10, A_speedR1=7'h11, A_speedR2=7'h12, A_dirL=7'h20, A_speedL1=7'h21, A_speedL2=7'h22), shared with the responder.
- One sub-module: sync_2ff for MySPI_miso.

## Test plan
- Write A_Config=8'h05 to the responder (bench instance, Status=9'h0AA) -> responder Config becomes 8'h05 after CS rises; MOSI stream 16'h8005; done once.
- Read A_Status with Status=9'h0AA -> rdata=8'hAA at done; MOSI first byte 8'h01.
- Read A_speedR1 / A_speedR2 with speedR=16'h1234 -> rdata 8'h12 then 8'h34, issued back-to-back on busy fall.
- start pulsed during busy -> ignored; exactly one done; pin waveform unchanged.
- theReset asserted at bit 6 of a write -> next cycle CS=1, SCLK=0, busy=0, no done; responder Config unchanged.
- Edge checks at HALF_PERIOD=8: cycle counts match Timing formulas; MOSI changes only while SCLK low.
